// File: rtl/ooo_pkg.sv
// ooo_pkg: shared widths and defaults for the out-of-order issue path.
//   INST_ID_BIT_DFLT     instruction id width
//   REG_ID_BIT_DFLT      architectural register id width
//   IMM_BIT_DFLT         immediate width
//   SPEC_DEPTH_DFLT      number of outstanding speculative branch levels
//   SPEC_LEVEL_BIT_DFLT  width of a speculation level (0..SPEC_DEPTH)
//   GRANT_CNT_BIT        width of one per-FIFO grant counter
package ooo_pkg;

    localparam int unsigned INST_ID_BIT_DFLT    = 8;
    localparam int unsigned REG_ID_BIT_DFLT     = 3;
    localparam int unsigned IMM_BIT_DFLT        = 4;
    localparam int unsigned SPEC_DEPTH_DFLT     = 4;
    localparam int unsigned SPEC_LEVEL_BIT_DFLT = $clog2(SPEC_DEPTH_DFLT) + 1;

    localparam int unsigned GRANT_CNT_BIT = 16;
    localparam logic [GRANT_CNT_BIT-1:0] GRANT_CNT_MAX = '1;

endpackage : ooo_pkg

// File: rtl/issue_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req starting at rr_ptr, ascending, wrapping NUM_FIFO-1 -> 0,
// and returns the first requester found.
//   req        in   NUM_FIFO  request vector
//   rr_ptr     in   SRC_BIT   index where the search starts
//   grant      out  NUM_FIFO  one-hot pick (all zero when req is zero)
//   grant_idx  out  SRC_BIT   index of the pick
//   grant_any  out  1         some request was found
module rr_pick
    import ooo_pkg::*;
#(
    parameter int unsigned NUM_FIFO = 4,
    parameter int unsigned SRC_BIT  = $clog2(NUM_FIFO)
) (
    input  logic [NUM_FIFO-1:0] req,
    input  logic [SRC_BIT-1:0]  rr_ptr,
    output logic [NUM_FIFO-1:0] grant,
    output logic [SRC_BIT-1:0]  grant_idx,
    output logic                grant_any
);

    int unsigned pos;

    // First requester at or after rr_ptr in circular order.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = 0;
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            pos = (32'(rr_ptr) + i) % NUM_FIFO;
            if (!grant_any && req[SRC_BIT'(pos)]) begin
                grant[SRC_BIT'(pos)] = 1'b1;
                grant_idx            = SRC_BIT'(pos);
                grant_any            = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/issue_arbiter.sv
// issue_arbiter: round-robin arbiter draining NUM_FIFO issue FIFO heads into
// one functional unit through a single output entry register. The held entry
// tracks branch resolution: a failing branch at or below its level kills it,
// a succeeding branch remaps its speculation level.
//
// Optional feature macro: ISSUE_ARB_GRANT_CNT_EN adds per-FIFO saturating
// 16-bit grant counters on output grant_cnt.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_vld / req_rdy          per-FIFO head valid / grant (pop), req_rdy combinational
//   req_id .. req_spec_level   flattened per-FIFO head payload, FIFO k at slice k
//   out_vld / out_rdy          issue handshake toward the functional unit
//   out_id .. out_spec_level   held payload (spec level remapped in a success cycle)
//   out_src                    FIFO index the held entry came from
//   br_pred_*                  branch resolution (always accepted)
//   grant_cnt                  per-FIFO grant counters (ISSUE_ARB_GRANT_CNT_EN only)
module issue_arbiter
    import ooo_pkg::*;
#(
    parameter int unsigned NUM_FIFO       = 4,
    parameter int unsigned INST_ID_BIT    = INST_ID_BIT_DFLT,
    parameter int unsigned REG_ID_BIT     = REG_ID_BIT_DFLT,
    parameter int unsigned IMM_BIT        = IMM_BIT_DFLT,
    parameter int unsigned SPEC_DEPTH     = SPEC_DEPTH_DFLT,
    parameter int unsigned SPEC_LEVEL_BIT = SPEC_LEVEL_BIT_DFLT,
    parameter int unsigned SRC_BIT        = $clog2(NUM_FIFO)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,

    input  logic [NUM_FIFO-1:0]                      req_vld,
    output logic [NUM_FIFO-1:0]                      req_rdy,
    input  logic [NUM_FIFO*INST_ID_BIT-1:0]          req_id,
    input  logic [NUM_FIFO*REG_ID_BIT-1:0]           req_dst_reg,
    input  logic [NUM_FIFO*REG_ID_BIT-1:0]           req_src_reg0,
    input  logic [NUM_FIFO*REG_ID_BIT-1:0]           req_src_reg1,
    input  logic [NUM_FIFO*IMM_BIT-1:0]              req_imm,
    input  logic [NUM_FIFO*SPEC_LEVEL_BIT-1:0]       req_spec_level,

    output logic                                     out_vld,
    input  logic                                     out_rdy,
    output logic [INST_ID_BIT-1:0]                   out_id,
    output logic [REG_ID_BIT-1:0]                    out_dst_reg,
    output logic [REG_ID_BIT-1:0]                    out_src_reg0,
    output logic [REG_ID_BIT-1:0]                    out_src_reg1,
    output logic [IMM_BIT-1:0]                       out_imm,
    output logic [SPEC_LEVEL_BIT-1:0]                out_spec_level,
    output logic [SRC_BIT-1:0]                       out_src,

    input  logic                                     br_pred_vld,
    output logic                                     br_pred_rdy,
    input  logic                                     br_pred_succ,
    input  logic [SPEC_LEVEL_BIT-1:0]                br_pred_fail_level,
    input  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels
`ifdef ISSUE_ARB_GRANT_CNT_EN
    ,
    output logic [NUM_FIFO*GRANT_CNT_BIT-1:0]        grant_cnt
`endif
);

    // Per-FIFO views of the flattened payload buses.
    logic [INST_ID_BIT-1:0]    fifo_id   [NUM_FIFO];
    logic [REG_ID_BIT-1:0]     fifo_dst  [NUM_FIFO];
    logic [REG_ID_BIT-1:0]     fifo_src0 [NUM_FIFO];
    logic [REG_ID_BIT-1:0]     fifo_src1 [NUM_FIFO];
    logic [IMM_BIT-1:0]        fifo_imm  [NUM_FIFO];
    logic [SPEC_LEVEL_BIT-1:0] fifo_spec [NUM_FIFO];
    logic [SPEC_LEVEL_BIT-1:0] nxt_level [SPEC_DEPTH+1];

    for (genvar k = 0; k < NUM_FIFO; k++) begin : g_unpack
        assign fifo_id[k]   = req_id[k*INST_ID_BIT +: INST_ID_BIT];
        assign fifo_dst[k]  = req_dst_reg[k*REG_ID_BIT +: REG_ID_BIT];
        assign fifo_src0[k] = req_src_reg0[k*REG_ID_BIT +: REG_ID_BIT];
        assign fifo_src1[k] = req_src_reg1[k*REG_ID_BIT +: REG_ID_BIT];
        assign fifo_imm[k]  = req_imm[k*IMM_BIT +: IMM_BIT];
        assign fifo_spec[k] = req_spec_level[k*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT];
    end

    for (genvar l = 0; l <= SPEC_DEPTH; l++) begin : g_nxt
        assign nxt_level[l] = br_pred_succ_nxt_levels[l*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT];
    end

    // Output entry register and round-robin pointer.
    logic                      held_vld;
    logic [INST_ID_BIT-1:0]    held_id;
    logic [REG_ID_BIT-1:0]     held_dst;
    logic [REG_ID_BIT-1:0]     held_src0;
    logic [REG_ID_BIT-1:0]     held_src1;
    logic [IMM_BIT-1:0]        held_imm;
    logic [SPEC_LEVEL_BIT-1:0] held_spec;
    logic [SRC_BIT-1:0]        held_src;
    logic [SRC_BIT-1:0]        rr_ptr;

    logic [NUM_FIFO-1:0]       pick_oh;
    logic [SRC_BIT-1:0]        pick_idx;
    logic                      pick_any;

    logic                      held_kill;
    logic                      drain;
    logic                      slot_free;
    logic                      grant_any;
    logic                      br_succ;
    logic [SPEC_LEVEL_BIT-1:0] remap_level;

    rr_pick #(
        .NUM_FIFO (NUM_FIFO),
        .SRC_BIT  (SRC_BIT)
    ) u_rr_pick (
        .req       (req_vld),
        .rr_ptr    (rr_ptr),
        .grant     (pick_oh),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // Level the held entry moves to when its older branch resolves correctly;
    // an out-of-range level keeps its value.
    always_comb begin
        remap_level = held_spec;
        if (32'(held_spec) <= SPEC_DEPTH) begin
            remap_level = nxt_level[held_spec];
        end
    end

    // Kill, drain and slot-free decode; a kill or drain frees the slot for a
    // grant in the same cycle. rst_n gates req_rdy so no FIFO pops in reset.
    always_comb begin
        br_succ   = br_pred_vld && br_pred_succ;
        held_kill = br_pred_vld && !br_pred_succ && held_vld &&
                    (held_spec >= br_pred_fail_level);
        out_vld   = held_vld && !held_kill;
        drain     = out_vld && out_rdy;
        slot_free = !held_vld || drain || held_kill;
        grant_any = rst_n && slot_free && pick_any;
        req_rdy   = grant_any ? pick_oh : '0;
    end

    assign out_id         = held_id;
    assign out_dst_reg    = held_dst;
    assign out_src_reg0   = held_src0;
    assign out_src_reg1   = held_src1;
    assign out_imm        = held_imm;
    assign out_src        = held_src;
    assign out_spec_level = br_succ ? remap_level : held_spec;
    assign br_pred_rdy    = 1'b1;

    // Entry load / clear / remap and pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_vld  <= 1'b0;
            held_id   <= '0;
            held_dst  <= '0;
            held_src0 <= '0;
            held_src1 <= '0;
            held_imm  <= '0;
            held_spec <= '0;
            held_src  <= '0;
            rr_ptr    <= '0;
        end else if (grant_any) begin
            held_vld  <= 1'b1;
            held_id   <= fifo_id[pick_idx];
            held_dst  <= fifo_dst[pick_idx];
            held_src0 <= fifo_src0[pick_idx];
            held_src1 <= fifo_src1[pick_idx];
            held_imm  <= fifo_imm[pick_idx];
            held_spec <= fifo_spec[pick_idx];
            held_src  <= pick_idx;
            rr_ptr    <= (pick_idx == SRC_BIT'(NUM_FIFO - 1)) ? '0
                                                              : pick_idx + SRC_BIT'(1);
        end else if (drain || held_kill) begin
            held_vld  <= 1'b0;
        end else if (br_succ && held_vld) begin
            held_spec <= remap_level;
        end
    end

`ifdef ISSUE_ARB_GRANT_CNT_EN
    // Saturating per-FIFO grant counters.
    for (genvar k = 0; k < NUM_FIFO; k++) begin : g_cnt
        logic [GRANT_CNT_BIT-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (req_rdy[k] && (cnt != GRANT_CNT_MAX)) begin
                cnt <= cnt + GRANT_CNT_BIT'(1);
            end
        end

        assign grant_cnt[k*GRANT_CNT_BIT +: GRANT_CNT_BIT] = cnt;
    end
`endif

endmodule : issue_arbiter

// File: tb/tb_issue_arbiter.sv
// tb_issue_arbiter: randomized and directed bench for issue_arbiter with a
// transaction-level reference model (one held entry + a rotating priority index).
// Build with ISSUE_ARB_GRANT_CNT_EN to also exercise the grant counters.
module tb_issue_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 8;
    localparam int unsigned RW  = 3;
    localparam int unsigned IW  = 4;
    localparam int unsigned SD  = 4;
    localparam int unsigned SLW = 3;
    localparam int unsigned SW  = 2;
    localparam int unsigned NLW = SLW * (SD + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_vld;
    logic [N-1:0]     req_rdy;
    logic [N*IDW-1:0] req_id;
    logic [N*RW-1:0]  req_dst_reg;
    logic [N*RW-1:0]  req_src_reg0;
    logic [N*RW-1:0]  req_src_reg1;
    logic [N*IW-1:0]  req_imm;
    logic [N*SLW-1:0] req_spec_level;
    logic             out_vld;
    logic             out_rdy;
    logic [IDW-1:0]   out_id;
    logic [RW-1:0]    out_dst_reg;
    logic [RW-1:0]    out_src_reg0;
    logic [RW-1:0]    out_src_reg1;
    logic [IW-1:0]    out_imm;
    logic [SLW-1:0]   out_spec_level;
    logic [SW-1:0]    out_src;
    logic             br_pred_vld;
    logic             br_pred_rdy;
    logic             br_pred_succ;
    logic [SLW-1:0]   br_pred_fail_level;
    logic [NLW-1:0]   br_pred_succ_nxt_levels;
`ifdef ISSUE_ARB_GRANT_CNT_EN
    logic [N*16-1:0]  grant_cnt;
`endif

    issue_arbiter #(.NUM_FIFO(N)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .req_vld                 (req_vld),
        .req_rdy                 (req_rdy),
        .req_id                  (req_id),
        .req_dst_reg             (req_dst_reg),
        .req_src_reg0            (req_src_reg0),
        .req_src_reg1            (req_src_reg1),
        .req_imm                 (req_imm),
        .req_spec_level          (req_spec_level),
        .out_vld                 (out_vld),
        .out_rdy                 (out_rdy),
        .out_id                  (out_id),
        .out_dst_reg             (out_dst_reg),
        .out_src_reg0            (out_src_reg0),
        .out_src_reg1            (out_src_reg1),
        .out_imm                 (out_imm),
        .out_spec_level          (out_spec_level),
        .out_src                 (out_src),
        .br_pred_vld             (br_pred_vld),
        .br_pred_rdy             (br_pred_rdy),
        .br_pred_succ            (br_pred_succ),
        .br_pred_fail_level      (br_pred_fail_level),
        .br_pred_succ_nxt_levels (br_pred_succ_nxt_levels)
`ifdef ISSUE_ARB_GRANT_CNT_EN
        ,
        .grant_cnt               (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the single held entry plus the index that has priority.
    bit m_vld;
    int m_rr;
    int m_id, m_dst, m_s0, m_s1, m_imm, m_spec, m_src;

    int p_id [N];
    int p_dst[N];
    int p_s0 [N];
    int p_s1 [N];
    int p_imm[N];
    int p_spec[N];
    int force_spec = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_vld = 1'b0;
        m_rr  = 0;
    endfunction

    // Reset applied at a negedge; outputs must drop at once and no FIFO may pop.
    task automatic do_reset();
        req_vld = '1;
        rst_n   = 1'b0;
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus, starting and ending at a negedge; checks the
    // combinational view against the model, then advances the model.
    task automatic cycle(input logic [N-1:0] vld, input logic ordy, input logic bv,
                         input logic bs, input logic [SLW-1:0] fl, input logic [NLW-1:0] nxt,
                         output logic [N-1:0] o_rdy, output logic o_vld,
                         output logic [SLW-1:0] o_spec, output logic [SW-1:0] o_src);
        bit kill, e_vld, free;
        int g, lvl, e_rdy;
        logic [20:0] exp_pl;
        for (int k = 0; k < N; k++) begin
            p_id[k]   = int'($urandom_range(0, 255));
            p_dst[k]  = int'($urandom_range(0, 7));
            p_s0[k]   = int'($urandom_range(0, 7));
            p_s1[k]   = int'($urandom_range(0, 7));
            p_imm[k]  = int'($urandom_range(0, 15));
            p_spec[k] = (force_spec >= 0) ? force_spec : int'($urandom_range(0, SD));
            req_id[k*IDW +: IDW]         = IDW'(p_id[k]);
            req_dst_reg[k*RW +: RW]      = RW'(p_dst[k]);
            req_src_reg0[k*RW +: RW]     = RW'(p_s0[k]);
            req_src_reg1[k*RW +: RW]     = RW'(p_s1[k]);
            req_imm[k*IW +: IW]          = IW'(p_imm[k]);
            req_spec_level[k*SLW +: SLW] = SLW'(p_spec[k]);
        end
        req_vld                 = vld;
        out_rdy                 = ordy;
        br_pred_vld             = bv;
        br_pred_succ            = bs;
        br_pred_fail_level      = fl;
        br_pred_succ_nxt_levels = nxt;
        #1;
        kill  = bv && !bs && m_vld && (m_spec >= int'(fl));
        e_vld = m_vld && !kill;
        free  = !m_vld || (e_vld && ordy) || kill;
        g = -1;
        if (free) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && vld[(m_rr + i) % N]) g = (m_rr + i) % N;
            end
        end
        e_rdy = (g >= 0) ? (1 << g) : 0;
        lvl   = (bv && bs) ? int'(nxt[m_spec*SLW +: SLW]) : m_spec;
        chk("req_rdy", 64'(req_rdy), 64'(e_rdy));
        chk("out_vld", 64'(out_vld), 64'(e_vld));
        chk("br_pred_rdy", 64'(br_pred_rdy), 64'd1);
        if (e_vld) begin
            exp_pl = {IDW'(m_id), RW'(m_dst), RW'(m_s0), RW'(m_s1), IW'(m_imm)};
            chk("payload", 64'({out_id, out_dst_reg, out_src_reg0, out_src_reg1, out_imm}),
                64'(exp_pl));
            chk("out_spec_level", 64'(out_spec_level), 64'(lvl));
            chk("out_src", 64'(out_src), 64'(m_src));
        end
        o_rdy  = req_rdy;
        o_vld  = out_vld;
        o_spec = out_spec_level;
        o_src  = out_src;
        @(posedge clk);
        if (g >= 0) begin
            m_vld  = 1'b1;
            m_id   = p_id[g];
            m_dst  = p_dst[g];
            m_s0   = p_s0[g];
            m_s1   = p_s1[g];
            m_imm  = p_imm[g];
            m_spec = p_spec[g];
            m_src  = g;
            m_rr   = (g + 1) % N;
        end else if (kill || (e_vld && ordy)) begin
            m_vld = 1'b0;
        end else if (bv && bs && m_vld) begin
            m_spec = lvl;
        end
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]   r;
        logic           v;
        logic [SLW-1:0] s;
        logic [SW-1:0]  src;
        logic [N-1:0]   seq28 [5];
        logic [N-1:0]   seq29 [3];
        logic [NLW-1:0] nxt31;

        seq28 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq29 = '{4'b1000, 4'b0010, 4'b1000};
        nxt31 = 15'b100_011_001_001_000;

        m_id = 0; m_dst = 0; m_s0 = 0; m_s1 = 0; m_imm = 0; m_spec = 0; m_src = 0;
        req_vld = '0; out_rdy = 1'b0; br_pred_vld = 1'b0; br_pred_succ = 1'b0;
        br_pred_fail_level = '0; br_pred_succ_nxt_levels = '0;
        req_id = '0; req_dst_reg = '0; req_src_reg0 = '0; req_src_reg1 = '0;
        req_imm = '0; req_spec_level = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // All FIFOs requesting: strict rotation, out_src one cycle behind.
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
            chk("rr_all_grant", 64'(r), 64'(seq28[i]));
            if (i > 0) chk("rr_all_src", 64'(src), 64'((i - 1) % 4));
        end

        // Sparse requesters with wrap from index 3 back to 1.
        do_reset();
        cycle(4'b0011, 1'b1, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
        cycle(4'b0011, 1'b1, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1010, 1'b1, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
            chk("rr_wrap_grant", 64'(r), 64'(seq29[i]));
        end

        // Kill of a stalled entry frees the slot for a grant in the same cycle.
        do_reset();
        force_spec = 2;
        cycle(4'b0001, 1'b0, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
        chk("kill_load", 64'(r), 64'b0001);
        cycle(4'b0001, 1'b0, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
        chk("kill_stall_rdy", 64'(r), 64'd0);
        chk("kill_stall_vld", 64'(v), 64'd1);
        cycle(4'b0001, 1'b0, 1'b1, 1'b0, 3'd1, 15'd0, r, v, s, src);
        chk("kill_vld", 64'(v), 64'd0);
        chk("kill_regrant", 64'(r), 64'b0001);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
        chk("kill_new_vld", 64'(v), 64'd1);

        // Successful branch remaps the held level from 2 to 1, visible at once.
        cycle(4'b0000, 1'b0, 1'b1, 1'b1, 3'd0, nxt31, r, v, s, src);
        chk("remap_now", 64'(s), 64'd1);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
        chk("remap_kept", 64'(s), 64'd1);
        chk("remap_vld", 64'(v), 64'd1);
        force_spec = -1;

        // Backpressure freezes grants; priority resumes where it stopped.
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b0, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
            chk("stall_rdy", 64'(r), 64'd0);
        end
        cycle(4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
        chk("stall_resume", 64'(r), 64'b0010);

        // Mid-operation reset drops the held entry and restarts priority at 0.
        do_reset();
        cycle(4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
        chk("post_rst_grant", 64'(r), 64'b0001);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [NLW-1:0] nxt;
            for (int l = 0; l <= SD; l++) nxt[l*SLW +: SLW] = SLW'($urandom_range(0, SD));
            cycle(N'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
                  1'($urandom), SLW'($urandom_range(0, SD)), nxt, r, v, s, src);
        end

`ifdef ISSUE_ARB_GRANT_CNT_EN
        // Counter saturation on FIFO 1; the others stay at zero.
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            cycle(4'b0010, 1'b1, 1'b0, 1'b0, 3'd0, 15'd0, r, v, s, src);
        end
        chk("cnt1_sat", 64'(grant_cnt[31:16]), 64'hFFFF);
        chk("cnt0_zero", 64'(grant_cnt[15:0]), 64'd0);
        chk("cnt3_zero", 64'(grant_cnt[63:48]), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_issue_arbiter
